// File: rtl/clz_unit_pkg.sv
// Shared ALU package: shifter function codes, CLZ/CLO mode
// encodings and the clz_unit FSM state type.
package clz_unit_pkg;

  localparam logic [1:0] SHF_SLL = 2'b00;
  localparam logic [1:0] SHF_SRL = 2'b01;
  localparam logic [1:0] SHF_SRA = 2'b11;

  localparam logic MODE_CLZ = 1'b0;
  localparam logic MODE_CLO = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_STEP = 2'b01,
    ST_DONE = 2'b10
  } clz_state_t;

endpackage

// File: rtl/clz_step.sv
// One binary-search stage: if the top s bits of work are zero,
// shift work/norm left by s and add s to the count.
// Ports: work/norm/cnt/s in; next_work/next_norm/next_cnt out.
module clz_step #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] work,
  input  logic [WIDTH-1:0] norm,
  input  logic [CW-1:0]    cnt,
  input  logic [CW-1:0]    s,
  output logic [WIDTH-1:0] next_work,
  output logic [WIDTH-1:0] next_norm,
  output logic [CW-1:0]    next_cnt
);

  logic [WIDTH-1:0] top_mask;
  logic             top_zero;

  // Mask with the upper s bits set.
  assign top_mask = ~({WIDTH{1'b1}} >> s);
  assign top_zero = (work & top_mask) == '0;

  always_comb begin
    next_work = work;
    next_norm = norm;
    next_cnt  = cnt;
    if (top_zero) begin
      next_work = work << s;
      next_norm = norm << s;
      next_cnt  = cnt + s;
    end
  end

endmodule

// File: rtl/clz_unit.sv
// Multi-cycle count-leading-zeros/ones, one search stage per clock.
// Ports: clk, reset, flush; in_valid/in_ready/in_data/in_mode;
// out_valid/out_ready/out_count/out_norm.
module clz_unit
  import clz_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic [WIDTH-1:0] out_norm
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [KW-1:0] K_TOP = KW'(KW - 1);

  clz_state_t       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] norm_q, norm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KW-1:0]    k_q, k_d;

  logic [CW-1:0]    s;
  logic [WIDTH-1:0] step_work;
  logic [WIDTH-1:0] step_norm;
  logic [CW-1:0]    step_cnt;

  assign s = CW'(1) << k_q;

  clz_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step (
    .work      (work_q),
    .norm      (norm_q),
    .cnt       (cnt_q),
    .s         (s),
    .next_work (step_work),
    .next_norm (step_norm),
    .next_cnt  (step_cnt)
  );

  assign in_ready  = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign out_count = cnt_q;
  assign out_norm  = norm_q;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    norm_d  = norm_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            work_d  = (in_mode == MODE_CLO) ? ~in_data : in_data;
            norm_d  = in_data;
            cnt_d   = '0;
            k_d     = K_TOP;
            state_d = ST_STEP;
          end
        end
        ST_STEP: begin
          work_d = step_work;
          norm_d = step_norm;
          cnt_d  = step_cnt;
          if (k_q == '0) begin
            // Top bit still clear: operand had no bit to find.
            if (!step_work[WIDTH-1]) begin
              cnt_d  = CW'(WIDTH);
              norm_d = '0;
            end
            state_d = ST_DONE;
          end else begin
            k_d = k_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      norm_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      norm_q  <= norm_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_clz_unit.sv
// Directed self-checking bench for clz_unit (WIDTH = 32).
// Expected counts/norms are hand-computed constants.
module tb_clz_unit;

  localparam int WIDTH = 32;
  localparam int CW    = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    out_count;
  logic [WIDTH-1:0] out_norm;

  int n_cmp = 0;
  int n_bad = 0;

  clz_unit #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_norm  (out_norm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand; returns after its accept edge.
  task automatic start_op(input logic [WIDTH-1:0] d,
                          input logic m);
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Edges from accept to out_valid, bounded.
  task automatic wait_done(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) begin
        n  = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [WIDTH-1:0] d,
                        input logic m,
                        input int exp_cnt,
                        input logic [WIDTH-1:0] exp_norm);
    int n;
    bit ok;
    start_op(d, m);
    wait_done(n, ok);
    chk({tag, " done"}, 64'(ok), 64'(1));
    chk({tag, " lat"}, 64'(n), 64'(5));
    chk({tag, " cnt"}, 64'(out_count), 64'(exp_cnt));
    chk({tag, " norm"}, 64'(out_norm), 64'(exp_norm));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " idle"}, 64'({in_ready, out_valid}), 64'(2'b10));
  endtask

  initial begin
    int n;
    bit ok;
    logic [CW-1:0]    hold_cnt;
    logic [WIDTH-1:0] hold_norm;

    tick();
    tick();
    reset = 1'b0;
    chk("rst in_ready", 64'(in_ready), 64'(1));
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst cnt", 64'(out_count), 64'(0));
    chk("rst norm", 64'(out_norm), 64'(0));

    run_op("clz 10000", 32'h0001_0000, 1'b0, 15, 32'h8000_0000);
    run_op("clz 0", 32'h0000_0000, 1'b0, 32, 32'h0000_0000);
    run_op("clz msb", 32'h8000_0000, 1'b0, 0, 32'h8000_0000);
    run_op("clz 1", 32'h0000_0001, 1'b0, 31, 32'h8000_0000);
    run_op("clo ffff0000", 32'hFFFF_0000, 1'b1, 16, 32'h0000_0000);
    run_op("clo ones", 32'hFFFF_FFFF, 1'b1, 32, 32'h0000_0000);
    run_op("clo 7fff", 32'h7FFF_FFFF, 1'b1, 0, 32'h7FFF_FFFF);
    run_op("clo fe", 32'hFE00_1234, 1'b1, 7, 32'h0009_1A00);

    // Backpressure with a second operand waiting.
    start_op(32'h0000_0F00, 1'b0);
    wait_done(n, ok);
    chk("bp done", 64'(ok), 64'(1));
    chk("bp cnt", 64'(out_count), 64'(20));
    chk("bp norm", 64'(out_norm), 64'(32'hF000_0000));
    hold_cnt  = out_count;
    hold_norm = out_norm;
    in_data  = 32'h4000_0000;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp valid", 64'(out_valid), 64'(1));
      chk("bp in_ready", 64'(in_ready), 64'(0));
      chk("bp cnt hold", 64'(out_count), 64'(hold_cnt));
      chk("bp norm hold", 64'(out_norm), 64'(hold_norm));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp handoff", 64'({in_ready, out_valid}), 64'(2'b10));
    tick();
    in_valid = 1'b0;
    chk("bp 2nd accept", 64'(in_ready), 64'(0));
    wait_done(n, ok);
    chk("bp 2nd done", 64'(ok), 64'(1));
    chk("bp 2nd lat", 64'(n), 64'(5));
    chk("bp 2nd cnt", 64'(out_count), 64'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Flush in the third STEP cycle.
    start_op(32'h0000_0001, 1'b0);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl idle", 64'({in_ready, out_valid}), 64'(2'b10));
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) ok = 1'b1;
    end
    chk("fl no valid", 64'(ok), 64'(0));
    run_op("fl next", 32'h4000_0000, 1'b0, 1, 32'h8000_0000);

    // Flush beats hand-off in DONE.
    start_op(32'h0000_00FF, 1'b0);
    wait_done(n, ok);
    chk("fl2 cnt", 64'(out_count), 64'(24));
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    chk("fl2 idle", 64'({in_ready, out_valid}), 64'(2'b10));

    // Reset while holding a result.
    start_op(32'h0000_0F00, 1'b0);
    wait_done(n, ok);
    chk("rs done", 64'(ok), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs out_valid", 64'(out_valid), 64'(0));
    chk("rs cnt", 64'(out_count), 64'(0));
    chk("rs norm", 64'(out_norm), 64'(0));
    chk("rs in_ready", 64'(in_ready), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
